minione_fetch: RTL

//  Instruction fetch unit feeding the minione executor. Reads 3-byte instructions
//  (mcode, opa, opb) from byte-wide program memory and presents them to the executor

---
 rtl/minione_fetch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/minione_fetch.sv
// Instruction fetch unit for the minione executor: assembles 3-byte instructions
// from byte-wide program memory and hands them over a valid/ready handshake.
module minione_fetch #(
    parameter int unsigned        ADDR_W = 16,
    parameter logic [ADDR_W-1:0]  RST_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        mcode,
    output logic [7:0]        opa,
    output logic [7:0]        opb,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F0   = 3'd1,
        S_F1   = 3'd2,
        S_F2   = 3'd3,
        S_HOLD = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [7:0]        mcode_q, mcode_d;
    logic [7:0]        opa_q, opa_d;
    logic [7:0]        opb_q, opb_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

    logic [ADDR_W-1:0] pc_p1, pc_p2, pc_p3;

    // PC offsets wrap naturally at the top of the address space
    assign pc_p1 = pc_q + ADDR_W'(1);
    assign pc_p2 = pc_q + ADDR_W'(2);
    assign pc_p3 = pc_q + ADDR_W'(3);

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        instr_valid_d = instr_valid_q;
        mcode_d       = mcode_q;
        opa_d         = opa_q;
        opb_d         = opb_q;
        instr_pc_d    = instr_pc_q;

        unique case (state_q)
            S_IDLE: begin
                if (fetch_en) begin
                    state_d    = S_F0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                end
            end
            S_F0: begin
                if (mem_ack) begin
                    mcode_d    = mem_rdata;
                    state_d    = S_F1;
                    mem_addr_d = pc_p1;
                end
            end
            S_F1: begin
                if (mem_ack) begin
                    opa_d      = mem_rdata;
                    state_d    = S_F2;
                    mem_addr_d = pc_p2;
                end
            end
            S_F2: begin
                if (mem_ack) begin
                    opb_d         = mem_rdata;
                    state_d       = S_HOLD;
                    mem_req_d     = 1'b0;
                    instr_valid_d = 1'b1;
                    instr_pc_d    = pc_q;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    pc_d          = pc_p3;
                    instr_valid_d = 1'b0;
                    state_d       = fetch_en ? S_F0 : S_IDLE;
                    mem_req_d     = fetch_en;
                    mem_addr_d    = pc_p3;
                end
            end
            default: begin
                state_d       = S_IDLE;
                mem_req_d     = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase

        // Redirect discards any partial or held instruction and wins over pc+3
        if (redir_valid) begin
            pc_d          = redir_pc;
            state_d       = fetch_en ? S_F0 : S_IDLE;
            mem_req_d     = fetch_en;
            mem_addr_d    = redir_pc;
            instr_valid_d = 1'b0;
            mcode_d       = mcode_q;
            opa_d         = opa_q;
            opb_d         = opb_q;
            instr_pc_d    = instr_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            pc_q          <= RST_PC;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            instr_valid_q <= 1'b0;
            mcode_q       <= 8'h00;
            opa_q         <= 8'h00;
            opb_q         <= 8'h00;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            instr_valid_q <= instr_valid_d;
            mcode_q       <= mcode_d;
            opa_q         <= opa_d;
            opb_q         <= opb_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = instr_valid_q;
    assign mcode       = mcode_q;
    assign opa         = opa_q;
    assign opb         = opb_q;
    assign instr_pc    = instr_pc_q;

endmodule
